// File: rtl/branch_hazard_controller.sv
// ID-stage branch hazard sequencer: detects producers that a beq/bne in IF/ID
// depends on, stalls the front end, then steers the comparator forwarding muxes.
module branch_hazard_controller #(
  parameter logic [5:0] BEQ_OP = 6'b000100,
  parameter logic [5:0] BNE_OP = 6'b000101,
  parameter int         CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       IFIDOpcode,
  input  logic [4:0]       IFIDRs,
  input  logic [4:0]       IFIDRt,
  input  logic [4:0]       IDEXRd,
  input  logic             IDEXRegWrite,
  input  logic             IDEXMemRead,
  input  logic [4:0]       EXMEMRd,
  input  logic             EXMEMRegWrite,
  input  logic             EXMEMMemRead,
  input  logic [4:0]       MEMWBRd,
  input  logic             MEMWBRegWrite,
  input  logic             BranchTaken,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             ControlMux,
  output logic             IFFlush,
  output logic [1:0]       BranchFwdA,
  output logic [1:0]       BranchFwdB,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_STALL = 1'b1;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  logic [0:0] state;
  logic [1:0] cnt;
  logic       is_br;
  logic [1:0] need_n;
  logic       stall;
  logic       idex_hit, exmem_hit;

  // $0 is hardwired zero, so it can never be a true dependency.
  function automatic logic match(input logic [4:0] x, input logic [4:0] r);
    return (x != 5'd0) && (x == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] r);
    if (EXMEMRegWrite && !EXMEMMemRead && match(EXMEMRd, r))
      return FWD_EXMEM;
    else if (MEMWBRegWrite && match(MEMWBRd, r))
      return FWD_MEMWB;
    else
      return FWD_RF;
  endfunction

  assign is_br     = (IFIDOpcode == BEQ_OP) || (IFIDOpcode == BNE_OP);
  assign idex_hit  = match(IDEXRd, IFIDRs) || match(IDEXRd, IFIDRt);
  assign exmem_hit = match(EXMEMRd, IFIDRs) || match(EXMEMRd, IFIDRt);

  // A load in ID/EX needs two cycles before its data reaches MEM/WB; an ALU
  // result in ID/EX or a load in EX/MEM needs one.
  always_comb begin
    need_n = 2'd0;
    if (state == S_IDLE && is_br) begin
      if (IDEXMemRead && IDEXRegWrite && idex_hit)
        need_n = 2'd2;
      else if (IDEXRegWrite && idex_hit)
        need_n = 2'd1;
      else if (EXMEMMemRead && EXMEMRegWrite && exmem_hit)
        need_n = 2'd1;
    end
  end

  assign stall = (state == S_STALL) || (need_n != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (need_n == 2'd2) begin
            state <= S_STALL;
            cnt   <= 2'd1;
          end
        end
        default: begin
          cnt <= cnt - 2'd1;
          if (cnt <= 2'd1) begin
            state <= S_IDLE;
            cnt   <= 2'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      StallCount <= '0;
    else if (stall && (StallCount != {CNT_W{1'b1}}))
      StallCount <= StallCount + 1'b1;
  end

  assign PCWrite    = ~stall;
  assign IFIDWrite  = ~stall;
  assign ControlMux = ~stall;
  assign IFFlush    = is_br & BranchTaken & ~stall;
  assign BranchFwdA = (is_br && !stall) ? fwd_sel(IFIDRs) : FWD_RF;
  assign BranchFwdB = (is_br && !stall) ? fwd_sel(IFIDRt) : FWD_RF;

endmodule

// File: tb/tb_branch_hazard_controller.sv
// Directed scenarios plus randomized traffic against a cycle-level reference
// model that tracks "remaining forced stalls" as a plain integer.
module tb_branch_hazard_controller;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, JOP = 6'b000010;

  logic clk, rst_n;
  logic [5:0] op;
  logic [4:0] rs, rt, exrd, mrd, wrd;
  logic exrw, exmr, mrw, mmr, wrw, tk;
  logic pcw, ifidw, cmux, flush;
  logic [1:0] fa, fb;
  logic [CNT_W-1:0] scnt;

  int n_chk = 0, n_err = 0;
  int m_busy, m_cnt;

  branch_hazard_controller #(.BEQ_OP(BEQ), .BNE_OP(BNE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFIDOpcode(op), .IFIDRs(rs), .IFIDRt(rt),
    .IDEXRd(exrd), .IDEXRegWrite(exrw), .IDEXMemRead(exmr),
    .EXMEMRd(mrd), .EXMEMRegWrite(mrw), .EXMEMMemRead(mmr),
    .MEMWBRd(wrd), .MEMWBRegWrite(wrw), .BranchTaken(tk),
    .PCWrite(pcw), .IFIDWrite(ifidw), .ControlMux(cmux), .IFFlush(flush),
    .BranchFwdA(fa), .BranchFwdB(fb), .StallCount(scnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_isbr();
    return (op == BEQ) || (op == BNE);
  endfunction

  function automatic bit uses(input logic [4:0] r);
    return (r != 0) && (r == rs || r == rt);
  endfunction

  function automatic int m_need();
    if (!m_isbr()) return 0;
    if (exrw && exmr && uses(exrd)) return 2;
    if (exrw && uses(exrd)) return 1;
    if (mrw && mmr && uses(mrd)) return 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    return (m_busy > 0) || (m_need() > 0);
  endfunction

  function automatic int m_fwd(input logic [4:0] r);
    if (!m_isbr() || m_stall() || r == 0) return 0;
    if (mrw && !mmr && mrd == r) return 1;
    if (wrw && wrd == r) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0;
      m_cnt  <= 0;
    end else begin
      if (m_busy > 0) m_busy <= m_busy - 1;
      else if (m_need() == 2) m_busy <= 1;
      if (m_stall() && m_cnt < CMAX) m_cnt <= m_cnt + 1;
    end
  end

  task automatic check_model(input string tag);
    int s;
    s = m_stall();
    chk({tag, ".pcw"},   pcw,   !s);
    chk({tag, ".ifidw"}, ifidw, !s);
    chk({tag, ".cmux"},  cmux,  !s);
    chk({tag, ".flush"}, flush, m_isbr() && tk && !s);
    chk({tag, ".fa"},    fa,    m_fwd(rs));
    chk({tag, ".fb"},    fb,    m_fwd(rt));
    chk({tag, ".cnt"},   scnt,  m_cnt);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] xd, input logic xw, input logic xm,
                       input logic [4:0] md, input logic mw, input logic mm,
                       input logic [4:0] wd, input logic ww, input logic k);
    op = o; rs = s; rt = t;
    exrd = xd; exrw = xw; exmr = xm;
    mrd = md; mrw = mw; mmr = mm;
    wrd = wd; wrw = ww; tk = k;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(6'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
    #3;
    chk("rst.pcw", pcw, 1);
    chk("rst.cmux", cmux, 1);
    chk("rst.flush", flush, 0);
    chk("rst.fa", fa, 0);
    chk("rst.cnt", scnt, 0);
    step();
    rst_n = 1'b1;

    // lw $2 in ID/EX, beq $2,$3 -> two stall cycles, then forward from MEM/WB
    step(); drive(BEQ, 5'd2, 5'd3, 5'd2, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0); #1;
    chk("lw.s1.pcw", pcw, 0);
    chk("lw.s1.fa", fa, 0);
    step(); drive(BEQ, 5'd2, 5'd3, 5'd0, 0, 0, 5'd2, 1, 1, 5'd0, 0, 0); #1;
    chk("lw.s2.pcw", pcw, 0);
    chk("lw.s2.ifidw", ifidw, 0);
    step(); drive(BEQ, 5'd2, 5'd3, 5'd0, 0, 0, 5'd0, 0, 0, 5'd2, 1, 0); #1;
    chk("lw.done.pcw", pcw, 1);
    chk("lw.done.fa", fa, 2);
    chk("lw.done.fb", fb, 0);
    chk("lw.done.cnt", scnt, 2);

    // add $4 in ID/EX, bne $5,$4 -> one stall, then forward B from EX/MEM
    step(); drive(BNE, 5'd5, 5'd4, 5'd4, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0); #1;
    chk("add.s1.pcw", pcw, 0);
    chk("add.s1.flush", flush, 0);
    step(); drive(BNE, 5'd5, 5'd4, 5'd0, 0, 0, 5'd4, 1, 0, 5'd0, 0, 0); #1;
    chk("add.done.pcw", pcw, 1);
    chk("add.done.fb", fb, 1);
    chk("add.done.fa", fa, 0);
    chk("add.done.cnt", scnt, 3);

    // EX/MEM and MEM/WB both write $6: EX/MEM wins, no stall
    step(); drive(BEQ, 5'd6, 5'd6, 5'd0, 0, 0, 5'd6, 1, 0, 5'd6, 1, 0); #1;
    chk("prio.fa", fa, 1);
    chk("prio.fb", fb, 1);
    chk("prio.pcw", pcw, 1);

    // $0 never hazards; taken branch flushes for one cycle only
    step(); drive(BEQ, 5'd0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 5'd0, 0, 1); #1;
    chk("r0.pcw", pcw, 1);
    chk("r0.flush", flush, 1);
    step(); drive(JOP, 5'd7, 5'd7, 5'd7, 1, 1, 5'd0, 0, 0, 5'd0, 0, 1); #1;
    chk("j.flush", flush, 0);
    chk("j.pcw", pcw, 1);

    // Reset while in STALL with cnt = 1
    step(); drive(BNE, 5'd9, 5'd1, 5'd9, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0); #1;
    chk("mid.s1.pcw", pcw, 0);
    step(); drive(JOP, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0); #1;
    chk("mid.s2.pcw", pcw, 0);
    rst_n = 1'b0; #1;
    chk("mid.rst.pcw", pcw, 1);
    chk("mid.rst.cnt", scnt, 0);
    step(); rst_n = 1'b1;
    step(); #1;
    chk("mid.after.pcw", pcw, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [5:0] o;
      step();
      case ($urandom_range(0, 3))
        0: o = BEQ;
        1: o = BNE;
        2: o = JOP;
        default: o = 6'($urandom);
      endcase
      drive(o, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      #1;
      check_model("rnd");
    end

    // Saturation: hold a load-use hazard until the counter pins at all-ones
    step(); rst_n = 1'b0; #1; rst_n = 1'b1;
    drive(BEQ, 5'd3, 5'd8, 5'd3, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0);
    for (int i = 0; i < CMAX + 10; i++) step();
    #1;
    chk("sat.full", scnt, CMAX);
    check_model("sat");
    step(); drive(6'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
    step(); drive(BEQ, 5'd3, 5'd8, 5'd3, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0); #1;
    chk("sat.stall", pcw, 0);
    step(); step(); drive(6'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0); #1;
    chk("sat.hold", scnt, CMAX);
    chk("sat.idle.pcw", pcw, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/branch_hazard_controller.md
Name: branch_hazard_controller

Overview:
Sequences the ID-stage branch resolution path of the five-stage pipeline. Detects data hazards between a beq/bne in IF/ID and older producers in ID/EX and EX/MEM. Stalls the front end for the required number of cycles and then drives the branch-comparator forwarding selects. Issues the IF flush for taken branches and keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
BEQ_OP, 6'b000100, beq opcode
BNE_OP, 6'b000101, bne opcode
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  in  1  core clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
IFIDOpcode  in  6  opcode of the instruction in IF/ID
IFIDRs  in  5  rs field of the instruction in IF/ID
IFIDRt  in  5  rt field of the instruction in IF/ID
IDEXRd  in  5  destination register of the instruction in ID/EX (already muxed rt/rd)
IDEXRegWrite  in  1  ID/EX writes the register file
IDEXMemRead  in  1  ID/EX is a load
EXMEMRd  in  5  destination register in EX/MEM
EXMEMRegWrite  in  1  EX/MEM writes the register file
EXMEMMemRead  in  1  EX/MEM is a load
MEMWBRd  in  5  destination register in MEM/WB
MEMWBRegWrite  in  1  MEM/WB writes the register file
BranchTaken  in  1  ID comparator result; valid only when the IF/ID instruction is a branch
PCWrite  out  1  1 = PC updates
IFIDWrite  out  1  1 = IF/ID updates
ControlMux  out  1  1 = pass control to ID/EX; 0 = insert bubble
IFFlush  out  1  zero IF/ID on the next edge
BranchFwdA  out  2  comparator A source: 00 = regfile, 01 = EX/MEM ALU result, 10 = MEM/WB write data
BranchFwdB  out  2  same as BranchFwdA, for comparator B
StallCount  out  CNT_W  total stall cycles since reset, saturating

Behaviour:
- is_br = (IFIDOpcode == BEQ_OP) | (IFIDOpcode == BNE_OP).
- match(x, r) = (x != 0) & (x == r), where r is IFIDRs or IFIDRt.
- Stall requirement N, evaluated only in IDLE with is_br = 1, highest rule first:
  - IDEXMemRead & IDEXRegWrite & match(IDEXRd) -> N = 2
  - IDEXRegWrite & match(IDEXRd) -> N = 1
  - EXMEMMemRead & EXMEMRegWrite & match(EXMEMRd) -> N = 1
  - otherwise N = 0
- State machine, 2 states: IDLE and STALL; 2-bit down-counter cnt.
  - IDLE, N = 0: stay in IDLE.
  - IDLE, N = 1: stall this cycle, stay in IDLE; detection re-evaluates next cycle.
  - IDLE, N = 2: stall this cycle, load cnt = 1, go to STALL.
  - STALL: stall; cnt decrements each cycle; when cnt == 1, next state is IDLE. Inputs are ignored in STALL.
- stall = (IDLE & N != 0) | STALL. The detection cycle is the first stall cycle, so stall is Mealy in IDLE.
- When stall = 1: PCWrite = 0, IFIDWrite = 0, ControlMux = 0. Otherwise all three are 1.
- IFFlush = is_br & BranchTaken & ~stall. It is never asserted during a stall cycle.
- BranchFwdA, evaluated with IFIDRs:
  - 01 if EXMEMRegWrite & ~EXMEMMemRead & match(EXMEMRd)
  - else 10 if MEMWBRegWrite & match(MEMWBRd)
  - else 00
  - EX/MEM has priority over MEM/WB.
- BranchFwdB: same rule, evaluated with IFIDRt.
- Both forwarding selects are forced to 00 when is_br = 0 or stall = 1.
- StallCount increments by 1 on every edge where stall = 1 and saturates at all-ones (no wrap).
- Reset (rst_n = 0, asynchronous, any time including mid-stall):
  - state = IDLE, cnt = 0, StallCount = 0.
  - Outputs settle to PCWrite = IFIDWrite = ControlMux = 1, IFFlush = 0, BranchFwdA = BranchFwdB = 00, given is_br = 0.
  - A stall in progress is abandoned. After reset release, detection restarts from IDLE.
- Non-branch opcodes in IF/ID never stall and never flush, including j.
- Register $0 never causes a hazard or a forward.

Test Plan:
- Reset mid-stall: in STALL with cnt = 1, assert rst_n = 0 -> state IDLE, PCWrite = 1, StallCount = 0 immediately, without waiting for a clock edge.
- lw $2 in ID/EX, beq $2,$3 in IF/ID -> stall exactly 2 cycles (PCWrite = 0 for 2 edges). Next cycle, with lw in MEM/WB: BranchFwdA = 10, StallCount = 2.
- add $4 in ID/EX, bne $5,$4 -> 1 stall cycle. Next cycle, with add in EX/MEM: BranchFwdB = 01, BranchFwdA = 00.
- Both EX/MEM and MEM/WB write $6, beq $6,$6 -> BranchFwdA = BranchFwdB = 01, no stall.
- beq $0,$0 with ID/EX lw $0 -> no stall. BranchTaken = 1 -> IFFlush = 1 for one cycle.
- Preload StallCount to all-ones, then cause a 2-cycle stall -> StallCount remains all-ones.
